// File: rtl/pe_pkg.sv
// Shared PE definitions: lane geometry, sequencer state encoding and lane-select helper.
package pe_pkg;

  localparam int unsigned LANES          = 4;
  localparam int unsigned ELEMS_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(LANES);
  localparam int unsigned ELEM_W         = $clog2(ELEMS_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_ACT     = 3'd4,
    ST_FINISH  = 3'd5
  } pe_state_e;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    return LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/pe_seq_ctrl.sv
// Sequencer for a 4-lane PE: loads weight words into lane FIFOs, streams activations
// through the MACs tile by tile, waits out the MAC pipeline and optionally fires activation.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH = 64,
  parameter int unsigned TILE_W        = 8,
  parameter int unsigned MAC_LAT       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TILE_W-1:0]        num_tiles,
  input  logic                     relu_en,
  input  logic                     w_valid,
  input  logic [DATA_IN_WIDTH-1:0] w_data,
  output logic                     w_ready,
  input  logic                     a_valid,
  input  logic [15:0]              a_data,
  output logic                     a_ready,
  output logic [LANES-1:0]         wr_en,
  output logic [LANES-1:0]         rd_en,
  output logic [LANES-1:0]         mac_en,
  output logic [LANES-1:0]         act_fn_en,
  output logic [DATA_IN_WIDTH-1:0] data_in,
  output logic [15:0]              in_ip,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1) + 1;

  pe_state_e           state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [TILE_W-1:0]   num_tiles_q, num_tiles_d;
  logic                relu_q, relu_d;
  logic [15:0]         in_ip_q;
  logic [LANES-1:0]    mac_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      elem_q      <= '0;
      tile_q      <= '0;
      drain_q     <= '0;
      num_tiles_q <= '0;
      relu_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      elem_q      <= elem_d;
      tile_q      <= tile_d;
      drain_q     <= drain_d;
      num_tiles_q <= num_tiles_d;
      relu_q      <= relu_d;
    end
  end

  // Next state, counters and the combinational handshake outputs.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    elem_d      = elem_q;
    tile_d      = tile_q;
    drain_d     = drain_q;
    num_tiles_d = num_tiles_q;
    relu_d      = relu_q;
    w_ready     = 1'b0;
    a_ready     = 1'b0;
    wr_en       = '0;
    rd_en       = '0;
    data_in     = '0;
    act_fn_en   = '0;
    done        = 1'b0;
    busy        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          num_tiles_d = num_tiles;
          relu_d      = relu_en;
          lane_d      = '0;
          elem_d      = '0;
          tile_d      = '0;
          drain_d     = '0;
          state_d     = (num_tiles == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wr_en   = lane_onehot(lane_q);
          data_in = w_data;
          if (lane_q == LANE_W'(LANES - 1)) begin
            lane_d  = '0;
            state_d = ST_COMPUTE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      ST_COMPUTE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          rd_en = '1;
          if (elem_q == ELEM_W'(ELEMS_PER_WORD - 1)) begin
            elem_d = '0;
            if (tile_q == num_tiles_q - TILE_W'(1)) begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end else begin
              tile_d  = tile_q + TILE_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            elem_d = elem_q + ELEM_W'(1);
          end
        end
      end
      // First DRAIN cycle carries the final mac_en; MAC_LAT more cycles follow it.
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(MAC_LAT)) begin
          drain_d = '0;
          state_d = relu_q ? ST_ACT : ST_FINISH;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_ACT: begin
        act_fn_en = '1;
        state_d   = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO read data appears one cycle after rd_en, so MAC operand and enable lag by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ip_q  <= '0;
      mac_en_q <= '0;
    end else begin
      mac_en_q <= rd_en;
      if (rd_en[0]) begin
        in_ip_q <= a_data;
      end
    end
  end

  assign in_ip  = in_ip_q;
  assign mac_en = mac_en_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: transaction-level reference model, directed
// scenarios plus randomized handshakes, cycle-by-cycle output comparison.
module tb_pe_seq_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 8;
  localparam int unsigned ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          relu_en;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          a_valid;
  logic [15:0]   a_data;
  logic          a_ready;
  logic [3:0]    wr_en, rd_en, mac_en, act_fn_en;
  logic [DW-1:0] data_in;
  logic [15:0]   in_ip;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_seq_ctrl #(.DATA_IN_WIDTH(DW), .TILE_W(TW), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .relu_en(relu_en),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .wr_en(wr_en), .rd_en(rd_en), .mac_en(mac_en), .act_fn_en(act_fn_en),
    .data_in(data_in), .in_ip(in_ip), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a job is n tiles of (4 weight handshakes, 4 activation handshakes),
  // followed by a tail measured in cycles since the last activation handshake.
  bit          m_job;
  int          m_n;
  bit          m_relu;
  int          m_tile, m_sub;
  bit          m_tail;
  int          m_p, m_act_p, m_done_p;
  bit          m_mac;
  logic [15:0] m_ip;
  int          wr_cnt, rd_cnt, act_cnt, done_cnt;

  task automatic model_reset();
    m_job = 0; m_tail = 0; m_mac = 0; m_ip = '0;
  endtask

  task automatic step(input bit st, input int n, input bit relu,
                      input bit wv, input logic [DW-1:0] wd,
                      input bit av, input logic [15:0] ad);
    logic [3:0]    e_wr, e_rd, e_mac, e_act;
    logic          e_busy, e_done, e_wrdy, e_ardy;
    logic [DW-1:0] e_din;
    bit            fired;
    start = st; num_tiles = TW'(n); relu_en = relu;
    w_valid = wv; w_data = wd; a_valid = av; a_data = ad;
    e_wr = '0; e_rd = '0; e_act = '0; e_busy = 0; e_done = 0;
    e_wrdy = 0; e_ardy = 0; e_din = '0;
    e_mac = m_mac ? 4'hF : 4'h0;
    if (m_job && !m_tail) begin
      e_busy = 1;
      if (m_sub < 4) begin
        e_wrdy = 1;
        if (wv) begin e_wr = 4'(1 << m_sub); e_din = wd; end
      end else begin
        e_ardy = 1;
        if (av) e_rd = 4'hF;
      end
    end else if (m_job) begin
      e_busy = 1;
      e_act  = (m_p == m_act_p) ? 4'hF : 4'h0;
      e_done = (m_p == m_done_p);
    end
    @(negedge clk);
    chk("ctl", {busy, done, w_ready, a_ready, wr_en, rd_en, mac_en, act_fn_en},
        {e_busy, e_done, e_wrdy, e_ardy, e_wr, e_rd, e_mac, e_act});
    chk("data_in", data_in, e_din);
    chk("in_ip", in_ip, m_ip);
    chk("overlap", {|(wr_en & rd_en), w_ready & a_ready, $countones(wr_en) > 1}, '0);
    if (wr_en != '0) wr_cnt++;
    if (rd_en != '0) rd_cnt++;
    if (act_fn_en != '0) act_cnt++;
    if (done) done_cnt++;
    m_mac = (e_rd != '0);
    if (e_rd != '0) m_ip = ad;
    if (!m_job) begin
      if (st) begin
        m_job = 1; m_n = n; m_relu = relu; m_tile = 0; m_sub = 0;
        if (n == 0) begin
          m_tail = 1; m_p = 1; m_done_p = 1; m_act_p = -1;
        end else begin
          m_tail = 0;
        end
      end
    end else if (!m_tail) begin
      fired = (m_sub < 4) ? wv : av;
      if (fired) begin
        if (m_sub == 7) begin
          if (m_tile == m_n - 1) begin
            m_tail   = 1; m_p = 1;
            m_act_p  = m_relu ? ML + 2 : -1;
            m_done_p = ML + 2 + int'(m_relu);
          end else begin
            m_tile++; m_sub = 0;
          end
        end else begin
          m_sub++;
        end
      end
    end else begin
      if (m_p == m_done_p) begin
        m_job = 0; m_tail = 0;
      end else begin
        m_p++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: always valid; 1: random valids; 2: gapped weights plus a 3-cycle activation stall.
  task automatic run_job(input int n, input bit relu, input int mode, input bit restart);
    int cyc, budget, stall;
    bit wv, av, st;
    wr_cnt = 0; rd_cnt = 0; act_cnt = 0; done_cnt = 0;
    step(1, n, relu, 0, '0, 0, '0);
    cyc = 0; stall = 3; budget = 20 * n + 50;
    while (m_job && cyc < budget) begin
      wv = 1; av = 1;
      if (mode == 1) begin
        wv = ($urandom_range(0, 3) != 0);
        av = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        wv = cyc[0];
        if (!m_tail && m_tile == 0 && m_sub == 6 && stall > 0) begin
          av = 0; stall--;
        end
      end
      st = restart && !m_tail && m_sub >= 4;
      step(st, st ? n + 3 : int'($urandom_range(0, 255)), $urandom_range(0, 1),
           wv, {$urandom, $urandom}, av, 16'($urandom));
      cyc++;
    end
    chk("timeout", {63'd0, m_job}, 64'd0);
    chk("wr_cnt", wr_cnt, 4 * n);
    chk("rd_cnt", rd_cnt, 4 * n);
    chk("act_cnt", act_cnt, (relu && n > 0) ? 1 : 0);
    chk("done_cnt", done_cnt, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_out", {busy, done, w_ready, a_ready, wr_en, rd_en, mac_en, act_fn_en},
        '0);
    chk("rst_data", {data_in, in_ip}, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start = 0; num_tiles = '0; relu_en = 0;
    w_valid = 0; w_data = '0; a_valid = 0; a_data = '0;
    model_reset();
    do_reset();

    // Single tile with activation, 0x3F80 operands.
    wr_cnt = 0; rd_cnt = 0; act_cnt = 0; done_cnt = 0;
    step(1, 1, 1, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, {$urandom, $urandom}, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0, 1, 16'h3F80);
    for (int i = 0; i < ML + 3; i++) step(0, 0, 0, 0, '0, 0, '0);
    chk("t1_wr", wr_cnt, 4);
    chk("t1_rd", rd_cnt, 4);
    chk("t1_act", act_cnt, 1);
    chk("t1_done", done_cnt, 1);
    step(0, 0, 0, 0, '0, 0, '0);

    run_job(0, 1, 0, 0);
    run_job(2, 0, 2, 0);
    run_job(2, 1, 0, 1);

    // Reset in the second COMPUTE cycle, then a clean single-tile job.
    step(1, 1, 1, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, {$urandom, $urandom}, 0, '0);
    step(0, 0, 0, 0, '0, 1, 16'h1234);
    a_valid = 1; a_data = 16'h5678;
    #1;
    do_reset();
    run_job(1, 1, 0, 0);

    for (int j = 0; j < 12; j++)
      run_job($urandom_range(1, 4), $urandom_range(0, 1), 1, $urandom_range(0, 1));
    run_job(255, 1, 1, 0);
    run_job(1, 0, 0, 0);
    step(0, 0, 0, 0, '0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 64: width of the weight word written into each lane FIFO (4 x bf16).
REQ-002 SHALL have parameter TILE_W, default 8: width of the tile-count input.
REQ-003 SHALL have parameter MAC_LAT, default 2: cycles from the last mac_en until the accumulator is stable.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: start  in  1  pulse that begins a job; num_tiles  in  TILE_W  number of 4-element tiles, sampled on start; relu_en  in  1  apply activation at end, sampled on start.
REQ-006 SHALL have ports: w_valid  in  1; w_data  in  DATA_IN_WIDTH; w_ready  out  1  valid/ready weight stream.
REQ-007 SHALL have ports: a_valid  in  1; a_data  in  16; a_ready  out  1  valid/ready bf16 activation stream.
REQ-008 SHALL have ports: wr_en, rd_en, mac_en, act_fn_en  out  4 each  per-lane PE controls; data_in  out  DATA_IN_WIDTH  FIFO write word; in_ip  out  16  shared MAC operand.
REQ-009 SHALL have ports: busy  out  1  job in progress; done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, LOAD, COMPUTE, DRAIN, ACT, FINISH.
REQ-011 IDLE: start=1 -> latch num_tiles and relu_en. If num_tiles=0 -> FINISH, else -> LOAD with lane=0, tile=0, elem=0. start is ignored in every other state.
REQ-012 LOAD: w_ready=1. Each w_valid&w_ready cycle -> wr_en = one-hot(lane), data_in = w_data (both combinational), lane++. The handshake at lane 3 -> COMPUTE. When w_valid=0 -> wr_en=0, no lane advance.
REQ-013 COMPUTE: a_ready=1. Each a_valid&a_ready cycle -> rd_en=4'b1111, elem++. When a_valid=0 -> rd_en=0 and the state holds (stall).
REQ-014 SHALL register in_ip <= a_data and mac_en <= rd_en, one cycle after each accepted activation (FIFO read latency 1). in_ip holds its value otherwise.
REQ-015 The handshake at elem=3 SHALL do the following: if tile=num_tiles-1 -> DRAIN, else tile++ and -> LOAD.
REQ-016 DRAIN: count MAC_LAT cycles starting after the final mac_en pulse, then -> ACT if the latched relu_en=1, else -> FINISH.
REQ-017 ACT: act_fn_en=4'b1111 for exactly one cycle, then -> FINISH.
REQ-018 FINISH: done=1 for one cycle, then -> IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE. w_ready and a_ready SHALL be 0 outside LOAD and COMPUTE respectively.
REQ-020 The tile counter SHALL be TILE_W bits. num_tiles = 2^TILE_W-1 SHALL complete without wrap. Counters SHALL NOT wrap mid-job.
REQ-021 wr_en and rd_en SHALL never be asserted in the same cycle. At most one wr_en bit SHALL be set at a time.

Reset
REQ-022 rst=1 SHALL force the state to IDLE asynchronously, in any state including mid-LOAD or mid-COMPUTE.
REQ-023 rst=1 SHALL clear all counters, latched config, in_ip and mac_en to 0.
REQ-024 While rst=1 and on the first cycle after reset, all outputs SHALL be 0.
REQ-025 The controller SHALL NOT clear PE accumulators; these reset via the shared rst only.

Structure
REQ-026 State encoding, LANES=4 and ELEMS_PER_WORD=4 SHALL live in the shared package pe_pkg.
REQ-027 No sub-module is required. pe_seq_ctrl SHALL instantiate nothing. A top level instantiates it beside PE.

Verification
REQ-028 num_tiles=1, relu_en=1, weights 4 words back-to-back, activations 0x3F80 x4 -> wr_en 0001,0010,0100,1000; then rd_en=1111 for 4 cycles; mac_en lags by 1; act_fn_en=1111 once; done pulses; busy falls next cycle.
REQ-029 num_tiles=0 -> busy for 1 cycle, done pulses, no wr/rd/mac/act enable ever set.
REQ-030 num_tiles=2 with w_valid gapped every other cycle and a_valid low for 3 cycles mid-tile -> exactly 8 wr_en and 8 rd_en pulses in order, no enable during stalls, relu_en=0 so act_fn_en stays 0.
REQ-031 start pulsed again during COMPUTE -> ignored; job completes with the original num_tiles.
REQ-032 rst asserted in the second COMPUTE cycle -> all outputs 0 immediately; a new start with num_tiles=1 then runs a complete, correct sequence.
REQ-033 Every test SHALL check that wr_en and rd_en never overlap and that w_ready and a_ready are never both 1.
